// File: rtl/nco_mc_tdm.sv
// nco_mc_tdm: time-division multiplexed quadrature NCO, NCH channels sharing one quarter-wave ROM pipeline.
// Optional LFSR phase dither is compiled in when NCO_DITHER_EN is defined.
module nco_mc_tdm #(
    parameter int    APR      = 32,
    parameter int    NCH      = 4,
    parameter int    CHW      = 2,
    parameter int    MPR      = 16,
    parameter int    LUT_AW   = 10,
    parameter string LUT_FILE = "nco_mc_qsin.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  cfg_wr,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic [APR-1:0]        cfg_inc,
    input  logic [APR-1:0]        cfg_ofs,
    input  logic                  cfg_load,
    input  logic                  sync_clr,
    output logic signed [MPR-1:0] fsin_o,
    output logic signed [MPR-1:0] fcos_o,
    output logic [CHW-1:0]        ch_o,
    output logic                  out_valid
);

    localparam int QW    = LUT_AW + 2;
    localparam int DEPTH = 2 ** LUT_AW;
`ifdef NCO_DITHER_EN
    localparam int PHW = APR;
`else
    localparam int PHW = QW;
`endif

    function automatic logic [MPR-2:0] qsin_entry(input int i);
        real amp;
        real ang;
        amp = real'((2 ** (MPR - 1)) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(DEPTH);
        return (MPR-1)'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    function automatic logic [LUT_AW:0] fold(input logic [1:0] q, input logic [LUT_AW-1:0] idx);
        return {q[1], (q[0] ? ~idx : idx)};
    endfunction

    function automatic logic signed [MPR-1:0] apply_sign(input logic [MPR-2:0] mag, input logic neg);
        logic signed [MPR-1:0] ext;
        ext = signed'({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // The table is built from its closed form; LUT_FILE only names the equivalent hex image.
    if (LUT_FILE == "") begin : g_lut_unnamed
    end

    logic [MPR-2:0] rom_w [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_w[g] = qsin_entry(g);
    end

    logic [APR-1:0] inc_sh_q  [NCH];
    logic [APR-1:0] ofs_sh_q  [NCH];
    logic [APR-1:0] inc_sh_d  [NCH];
    logic [APR-1:0] ofs_sh_d  [NCH];
    logic [APR-1:0] inc_act_q [NCH];
    logic [APR-1:0] ofs_act_q [NCH];
    logic [APR-1:0] acc_q     [NCH];
    logic [CHW-1:0] slot_q;
    logic [CHW-1:0] slot_d;

    logic [PHW-1:0]    phase_p1_q;
    logic [QW-1:0]     ph_top;
    logic [LUT_AW:0]   sin_f;
    logic [LUT_AW:0]   cos_f;
    logic [LUT_AW-1:0] sin_addr_p2_q, cos_addr_p2_q;
    logic              sin_neg_p2_q, cos_neg_p2_q, sin_neg_p3_q, cos_neg_p3_q;
    logic [MPR-2:0]    sin_mag_p3_q, cos_mag_p3_q;
    logic [CHW-1:0]    ch_p1_q, ch_p2_q, ch_p3_q;
    logic              vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

    // A write coinciding with cfg_load is visible to the commit through the _d view.
    always_comb begin
        inc_sh_d = inc_sh_q;
        ofs_sh_d = ofs_sh_q;
        if (cfg_wr && (int'(cfg_ch) < NCH)) begin
            inc_sh_d[cfg_ch] = cfg_inc;
            ofs_sh_d[cfg_ch] = cfg_ofs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                inc_sh_q[i]  <= '0;
                ofs_sh_q[i]  <= '0;
                inc_act_q[i] <= '0;
                ofs_act_q[i] <= '0;
            end
        end else begin
            inc_sh_q <= inc_sh_d;
            ofs_sh_q <= ofs_sh_d;
            if (cfg_load) begin
                inc_act_q <= inc_sh_d;
                ofs_act_q <= ofs_sh_d;
            end
        end
    end

    // S0: slot select and accumulate
    assign slot_d = (int'(slot_q) == NCH - 1) ? '0 : slot_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else if (clken) begin
            if (sync_clr) begin
                slot_q <= '0;
                for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
            end else begin
                acc_q[slot_q] <= acc_q[slot_q] + inc_act_q[slot_q];
                slot_q        <= slot_d;
            end
        end
    end

    // S1: optional dither, truncation and quadrant fold
`ifdef NCO_DITHER_EN
    localparam int DW = (APR - QW < 16) ? APR - QW : 16;
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (clken) begin
            lfsr_q <= sync_clr ? 16'hACE1
                               : ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000));
        end
    end

    assign ph_top = QW'((phase_p1_q + APR'(lfsr_q[DW-1:0])) >> (APR - QW));
`else
    assign ph_top = phase_p1_q;
`endif

    assign sin_f = fold(ph_top[QW-1 -: 2], ph_top[LUT_AW-1:0]);
    assign cos_f = fold(ph_top[QW-1 -: 2] + 2'd1, ph_top[LUT_AW-1:0]);

    always_ff @(posedge clk) begin
        if (clken) begin
            phase_p1_q    <= PHW'((acc_q[slot_q] + ofs_act_q[slot_q]) >> (APR - PHW));
            ch_p1_q       <= slot_q;
            sin_addr_p2_q <= sin_f[LUT_AW-1:0];
            cos_addr_p2_q <= cos_f[LUT_AW-1:0];
            sin_neg_p2_q  <= sin_f[LUT_AW];
            cos_neg_p2_q  <= cos_f[LUT_AW];
            ch_p2_q       <= ch_p1_q;
            // S2: dual-port ROM read
            sin_mag_p3_q  <= rom_w[sin_addr_p2_q];
            cos_mag_p3_q  <= rom_w[cos_addr_p2_q];
            sin_neg_p3_q  <= sin_neg_p2_q;
            cos_neg_p3_q  <= cos_neg_p2_q;
            ch_p3_q       <= ch_p2_q;
        end
    end

    // S3: sign restore and output register; sync_clr flushes every in-flight sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            fsin_o   <= '0;
            fcos_o   <= '0;
            ch_o     <= '0;
        end else if (clken) begin
            vld_p1_q <= !sync_clr;
            vld_p2_q <= vld_p1_q && !sync_clr;
            vld_p3_q <= vld_p2_q && !sync_clr;
            vld_p4_q <= vld_p3_q && !sync_clr;
            fsin_o   <= apply_sign(sin_mag_p3_q, sin_neg_p3_q);
            fcos_o   <= apply_sign(cos_mag_p3_q, cos_neg_p3_q);
            ch_o     <= ch_p3_q;
        end
    end

    // Held samples stay on the outputs, but are only flagged on enabled clocks so none is consumed twice.
    assign out_valid = vld_p4_q && clken;

endmodule

// File: tb/tb_nco_mc_tdm.sv
// tb_nco_mc_tdm: randomized bench for nco_mc_tdm against an ideal-phase sine/cosine reference model.
module tb_nco_mc_tdm;

    localparam int  APR    = 32;
    localparam int  NCH    = 4;
    localparam int  CHW    = 2;
    localparam int  MPR    = 16;
    localparam int  LUT_AW = 10;
    localparam int  LAT    = 4;
    localparam real PI     = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  clken;
    logic                  cfg_wr;
    logic [CHW-1:0]        cfg_ch;
    logic [APR-1:0]        cfg_inc;
    logic [APR-1:0]        cfg_ofs;
    logic                  cfg_load;
    logic                  sync_clr;
    logic signed [MPR-1:0] fsin_o;
    logic signed [MPR-1:0] fcos_o;
    logic [CHW-1:0]        ch_o;
    logic                  out_valid;

    nco_mc_tdm #(.APR(APR), .NCH(NCH), .CHW(CHW), .MPR(MPR), .LUT_AW(LUT_AW)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_ofs(cfg_ofs), .cfg_load(cfg_load), .sync_clr(sync_clr),
        .fsin_o(fsin_o), .fcos_o(fcos_o), .ch_o(ch_o), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-channel phase arithmetic plus a list of samples in flight.
    logic [APR-1:0] s_inc [NCH];
    logic [APR-1:0] s_ofs [NCH];
    logic [APR-1:0] a_inc [NCH];
    logic [APR-1:0] a_ofs [NCH];
    logic [APR-1:0] acc   [NCH];
    int  slot;
    bit  m_vld [LAT];
    int  m_ch  [LAT];
    int  m_k   [LAT];

    int  sin_seq [4] = '{25, 32767, -25, -32767};
    int  cos_seq [4] = '{32767, -25, -32767, 25};
    bit  lit_on = 1'b0;
    int  n0 = 0;
    int  en_cnt = 0;
    int  first_vld = -1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // k is the phase truncated to LUT_AW+2 bits; the ROM samples the centre of each phase bin.
    function automatic int exp_sin(input int k);
        return rnd(32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 4096.0));
    endfunction

    function automatic int exp_cos(input int k);
        return rnd(32767.0 * $cos(2.0 * PI * (real'(k) + 0.5) / 4096.0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            s_inc[i] = '0; s_ofs[i] = '0; a_inc[i] = '0; a_ofs[i] = '0; acc[i] = '0;
        end
        slot = 0;
        for (int s = 0; s < LAT; s++) begin
            m_vld[s] = 1'b0; m_ch[s] = 0; m_k[s] = 0;
        end
    endtask

    task automatic model_edge();
        logic [APR-1:0] ph;
        if (clken) begin
            en_cnt++;
            if (sync_clr) begin
                for (int i = 0; i < NCH; i++) acc[i] = '0;
                slot = 0;
                for (int s = 0; s < LAT; s++) m_vld[s] = 1'b0;
            end else begin
                for (int s = LAT - 1; s > 0; s--) begin
                    m_vld[s] = m_vld[s-1]; m_ch[s] = m_ch[s-1]; m_k[s] = m_k[s-1];
                end
                ph = acc[slot] + a_ofs[slot];
                m_vld[0] = 1'b1;
                m_ch[0]  = slot;
                m_k[0]   = int'(ph[APR-1 -: LUT_AW+2]);
                acc[slot] = acc[slot] + a_inc[slot];
                slot = (slot + 1) % NCH;
            end
        end
        if (cfg_wr && int'(cfg_ch) < NCH) begin
            s_inc[cfg_ch] = cfg_inc;
            s_ofs[cfg_ch] = cfg_ofs;
        end
        if (cfg_load) begin
            for (int i = 0; i < NCH; i++) begin
                a_inc[i] = s_inc[i]; a_ofs[i] = s_ofs[i];
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_vld[LAT-1] && clken);
        if (lit_on && first_vld < 0 && out_valid) first_vld = en_cnt;
        if (m_vld[LAT-1]) begin
            chk("ch_o", ch_o, m_ch[LAT-1]);
            chk("fsin", fsin_o, exp_sin(m_k[LAT-1]));
            chk("fcos", fcos_o, exp_cos(m_k[LAT-1]));
            if (lit_on && m_ch[LAT-1] == 0) begin
                chk("ch0_sin_seq", fsin_o, sin_seq[n0 % 4]);
                chk("ch0_cos_seq", fcos_o, cos_seq[n0 % 4]);
                if (clken) n0++;
            end
            if (lit_on && m_ch[LAT-1] == 2) begin
                chk("ch2_hold_sin", fsin_o, 25);
                chk("ch2_hold_cos", fcos_o, 32767);
            end
        end
    endtask

    task automatic step(input logic ce, input logic wr, input logic [CHW-1:0] ch,
                        input logic [APR-1:0] inc, input logic [APR-1:0] ofs,
                        input logic ld, input logic sc);
        clken = ce; cfg_wr = wr; cfg_ch = ch; cfg_inc = inc; cfg_ofs = ofs;
        cfg_load = ld; sync_clr = sc;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sin"}, fsin_o, 0);
        chk({tag, "_cos"}, fcos_o, 0);
        chk({tag, "_ch"}, ch_o, 0);
    endtask

    initial begin
        logic ce, sc;
        reset_n = 1'b0; clken = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
        cfg_inc = '0; cfg_ofs = '0; cfg_load = 1'b0; sync_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        // Configure with the pipeline frozen, then commit all channels together.
        step(1'b0, 1'b1, 2'd0, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 32'h0123_4567, 32'h8000_0000, 1'b1, 1'b0);
        lit_on = 1'b1;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
        chk("first_valid_cycle", first_vld, LAT);

        // Shadow write without commit leaves ch2 at phase 0.
        step(1'b1, 1'b1, 2'd2, 32'h2000_0000, 32'h0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
        lit_on = 1'b0;
        step(1'b1, 1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);

        // sync_clr with clken toggling around it.
        step(1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(i[0], 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom_range(0, 9) < 7);
            sc = ce && ($urandom_range(0, 99) < 2);
            step(ce, ($urandom_range(0, 9) == 0), CHW'($urandom_range(0, NCH - 1)),
                 $urandom, $urandom, ($urandom_range(0, 19) == 0), sc);
        end

        // Asynchronous reset in the middle of a running stream.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
        clken = 1'b1;
        reset_n = 1'b0;
        #2;
        check_reset_state("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 2'd0, 32'h0100_0000, 32'h0000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
